ctrl_mc: RTL and testbench

CTRL_MC -- requirements
Module: ctrl_mc

---
 rtl/ctrl_mc_pkg.sv | 32 +++
 rtl/ctrl_timer.sv | 15 +
 rtl/ctrl_mc.sv | 67 ++++++
 tb/tb_ctrl_mc.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ctrl_mc_pkg.sv
// ctrl_mc_pkg: RISC-V opcode constants, one-hot controller states and opcode class helpers
package ctrl_mc_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_FETCH  = 6'b000010,
    S_DECODE = 6'b000100,
    S_MEM    = 6'b001000,
    S_WB     = 6'b010000,
    S_TRAP   = 6'b100000
  } state_e;
  function automatic logic is_mem_op(input logic [6:0] op);
    return op == OPC_LOAD || op == OPC_STORE;
  endfunction
  function automatic logic is_wb_op(input logic [6:0] op);
    return op inside {OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC};
  endfunction
  function automatic logic writes_reg(input logic [6:0] op);
    return op inside {OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
  endfunction
  function automatic logic takes_branch(input logic [6:0] op);
    return op inside {OPC_BRANCH, OPC_JAL, OPC_JALR};
  endfunction
endpackage

// File: rtl/ctrl_timer.sv
// ctrl_timer: wait-cycle counter that runs while enabled and flags the last allowed cycle
module ctrl_timer #(
  parameter int TIMER_W = 8,
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = en ? cnt_q + TIMER_W'(1) : '0;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired = (LIMIT != 0) && en && (cnt_q == TIMER_W'(LIMIT - 1));
endmodule

// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle fetch/decode/mem/writeback controller with wait timeout and sticky trap
module ctrl_mc
  import ctrl_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMER_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [6:0]       INSTR,
  input  logic             INSTR_VALID,
  input  logic             DATA_VALID,
  output logic             INSTR_REQ,
  output logic             DATA_REQ,
  output logic             DATA_WRITE_ENABLE,
  output logic             REG_WRITE,
  output logic             BRANCH,
  output logic             TRAP,
  output logic [CNT_W-1:0] RETIRE_CNT
);
  state_e state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic waiting, expired;
  assign waiting = state_q == S_FETCH || state_q == S_MEM;
  ctrl_timer #(.TIMER_W(TIMER_W), .LIMIT(MEM_TIMEOUT)) u_timer (
    .clk(CLK),
    .rst(RES),
    .en(waiting),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        state_d = INSTR_VALID ? S_DECODE : expired ? S_TRAP : S_FETCH;
        opcode_d = INSTR_VALID ? INSTR : opcode_q;
      end
      S_DECODE: state_d = is_mem_op(opcode_q) ? S_MEM : is_wb_op(opcode_q) ? S_WB : S_TRAP;
      S_MEM:    state_d = DATA_VALID ? S_WB : expired ? S_TRAP : S_MEM;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
    retire_cnt_d = retire_cnt_q + CNT_W'(state_d == S_WB);
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= S_IDLE;
      opcode_q <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      opcode_q <= opcode_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end
  assign INSTR_REQ = state_q == S_FETCH;
  assign DATA_REQ = state_q == S_MEM;
  assign DATA_WRITE_ENABLE = state_q == S_MEM && opcode_q == OPC_STORE;
  assign REG_WRITE = state_q == S_WB && writes_reg(opcode_q);
  assign BRANCH = state_q == S_WB && takes_branch(opcode_q);
  assign TRAP = state_q == S_TRAP;
  assign RETIRE_CNT = retire_cnt_q;
endmodule

// File: tb/tb_ctrl_mc.sv
// tb_ctrl_mc: randomized transaction-level check of ctrl_mc against an instruction-lifecycle model
module tb_ctrl_mc;
  localparam int T = 4;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [5:0] E_IREQ = 6'b100000, E_DREQ = 6'b010000, E_DWE = 6'b001000;
  localparam logic [5:0] E_RW = 6'b000100, E_BR = 6'b000010, E_TRAP = 6'b000001;
  logic clk = 1'b0;
  logic res = 1'b1;
  logic [6:0] instr = '0;
  logic instr_valid = 1'b0, data_valid = 1'b0;
  logic instr_req, data_req, data_we, reg_write, branch, trap;
  logic [3:0] retire_cnt;
  int errors = 0, checks = 0, exp_cnt = 0;
  bit in_trap;
  logic [6:0] ops [9] = '{LOAD, STORE, BR, JAL, JALR, OP, OPI, LUI, AUIPC};
  ctrl_mc #(.MEM_TIMEOUT(T), .TIMER_W(8), .CNT_W(4)) dut (
    .CLK(clk),
    .RES(res),
    .INSTR(instr),
    .INSTR_VALID(instr_valid),
    .DATA_VALID(data_valid),
    .INSTR_REQ(instr_req),
    .DATA_REQ(data_req),
    .DATA_WRITE_ENABLE(data_we),
    .REG_WRITE(reg_write),
    .BRANCH(branch),
    .TRAP(trap),
    .RETIRE_CNT(retire_cnt)
  );
  always #5 clk = ~clk;
  wire [5:0] outs = {instr_req, data_req, data_we, reg_write, branch, trap};
  function automatic bit m_mem(input logic [6:0] o);
    return o == LOAD || o == STORE;
  endfunction
  function automatic bit m_wb(input logic [6:0] o);
    return o inside {BR, JAL, JALR, OP, OPI, LUI, AUIPC};
  endfunction
  function automatic logic [5:0] m_wb_out(input logic [6:0] o);
    return (o inside {LOAD, OP, OPI, LUI, AUIPC, JAL, JALR} ? E_RW : 6'b0) | (o inside {BR, JAL, JALR} ? E_BR : 6'b0);
  endfunction
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input string tag, input logic [5:0] e, input logic iv, input logic dv, input logic [6:0] ins);
    @(negedge clk);
    chk({tag, "_out"}, 32'(outs), 32'(e));
    chk({tag, "_cnt"}, 32'(retire_cnt), 32'(exp_cnt));
    instr_valid = iv;
    data_valid = dv;
    instr = ins;
  endtask
  task automatic do_reset();
    @(negedge clk);
    res = 1'b1;
    instr_valid = rb();
    data_valid = rb();
    instr = 7'($urandom);
    exp_cnt = 0;
    in_trap = 0;
    @(negedge clk);
    chk("idle_out", 32'(outs), 32'(0));
    chk("idle_cnt", 32'(retire_cnt), 32'(0));
    res = 1'b0;
    instr_valid = rb();
    data_valid = rb();
  endtask
  task automatic run_instr(input logic [6:0] op, input int df, input int dd, input bit rst_mid);
    logic v;
    for (int k = 0; k < 64; k++) begin
      v = (k == df);
      step("fetch", E_IREQ, v, rb(), v ? op : 7'($urandom));
      if (v) break;
      if (k == T - 1) begin
        in_trap = 1;
        return;
      end
    end
    step("decode", 6'b0, rb(), rb(), 7'($urandom));
    if (!m_mem(op) && !m_wb(op)) begin
      in_trap = 1;
      return;
    end
    if (m_mem(op)) begin
      for (int k = 0; k < 64; k++) begin
        v = (k == dd);
        step("mem", E_DREQ | (op == STORE ? E_DWE : 6'b0), rb(), v, 7'($urandom));
        if (rst_mid && k == 1) begin
          do_reset();
          return;
        end
        if (v) break;
        if (k == T - 1) begin
          in_trap = 1;
          return;
        end
      end
    end
    exp_cnt = (exp_cnt + 1) % 16;
    step("wb", m_wb_out(op), rb(), rb(), 7'($urandom));
  endtask
  task automatic run(input logic [6:0] op, input int df, input int dd);
    run_instr(op, df, dd, 1'b0);
    if (in_trap) begin
      repeat (3) step("trap", E_TRAP, rb(), rb(), 7'($urandom));
      do_reset();
    end
  endtask
  initial begin
    do_reset();
    run(OP, 0, 0);
    run(LOAD, 0, 3);
    run(STORE, 1, 2);
    run(JAL, 2, 0);
    run(OP, 9, 0);
    run(OP, 3, 0);
    run(STORE, 0, 9);
    run(7'b1111111, 0, 0);
    run_instr(LOAD, 0, 9, 1'b1);
    run(BR, 0, 0);
    do_reset();
    repeat (17) run(OP, 0, 0);
    chk("wrap_cnt", 32'(retire_cnt), 32'(1));
    repeat (200) begin
      run($urandom_range(0, 9) == 0 ? 7'($urandom) : ops[$urandom_range(0, 8)], $urandom_range(0, 4), $urandom_range(0, 4));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
